// File: rtl/core_result_collector.sv
// Per-core result buffer: push is seen on host_valid 1 cycle later; the head is shown with 0-cycle read latency.
// The core cannot be stalled, so a push while full is dropped unless a pop happens in the same cycle.
module core_result_collector #(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_BITS = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  core_valid,
    input  logic [1:0]            core_tag,
    input  logic [DATA_WIDTH-1:0] core_data,
    output logic                  host_valid,
    output logic [1:0]            host_tag,
    output logic [DATA_WIDTH-1:0] host_data,
    input  logic                  host_ready,
    output logic [DEPTH_BITS:0]   fill_level,
    output logic [CNT_WIDTH-1:0]  accepted_count,
    output logic [CNT_WIDTH-1:0]  dropped_count,
    output logic                  overflow,
    input  logic                  report
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL = (DEPTH_BITS + 1)'(DEPTH);

    typedef struct packed {
        logic [1:0]            tag;
        logic [DATA_WIDTH-1:0] dat;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  flush;

    // report only drives the simulation-side counter display; CORE labels that display.
    logic unused_report;
    assign unused_report = report ^ (CORE != 0);

    assign flush      = reset | clear;
    assign host_valid = (fill_level != '0);
    assign host_tag   = mem[rd_ptr].tag;
    assign host_data  = mem[rd_ptr].dat;
    assign pop        = host_valid & host_ready;
    assign push       = core_valid & ((fill_level != FULL) | pop);
    assign drop       = core_valid & ~push;

    // Storage is deliberately left out of reset; fill_level alone says what is valid.
    always_ff @(posedge clock) begin
        if (!flush && push) begin
            mem[wr_ptr] <= '{tag: core_tag, dat: core_data};
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill_level     <= '0;
            accepted_count <= '0;
            dropped_count  <= '0;
            overflow       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (accepted_count != '1) begin
                    accepted_count <= accepted_count + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (dropped_count != '1) begin
                    dropped_count <= dropped_count + 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
        end
    end
endmodule

// File: tb/tb_core_result_collector.sv
// Scoreboarded random/directed bench for core_result_collector; the queue depth is the reference occupancy.
module tb_core_result_collector;
    localparam int DW    = 32;
    localparam int DB    = 3;
    localparam int CW    = 4;
    localparam int DEPTH = 1 << DB;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset, clear, core_valid, host_valid, host_ready, overflow, report;
    logic [1:0]    core_tag, host_tag;
    logic [DW-1:0] core_data, host_data;
    logic [DB:0]   fill_level;
    logic [CW-1:0] accepted_count, dropped_count;

    core_result_collector #(.CORE(2), .DATA_WIDTH(DW), .DEPTH_BITS(DB), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .core_valid(core_valid), .core_tag(core_tag), .core_data(core_data),
        .host_valid(host_valid), .host_tag(host_tag), .host_data(host_data),
        .host_ready(host_ready), .fill_level(fill_level),
        .accepted_count(accepted_count), .dropped_count(dropped_count),
        .overflow(overflow), .report(report)
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            errors = 0;
    logic [DW+1:0] sbq[$];
    int            m_acc, m_drop;
    bit            m_ovf;
    bit            chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("host_valid", 64'(host_valid), 64'(sbq.size() != 0));
        chk("fill_level", 64'(fill_level), 64'(sbq.size()));
        chk("accepted_count", 64'(accepted_count), 64'(m_acc));
        chk("dropped_count", 64'(dropped_count), 64'(m_drop));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    // One clock: check current state, apply inputs, advance the reference model, wait for the edge.
    task automatic step(input bit rst, input bit clr, input bit cv, input logic [1:0] tg,
                        input logic [DW-1:0] d, input bit hr);
        bit pop_m;
        if (chk_en) check_state();
        reset = rst; clear = clr; core_valid = cv; core_tag = tg; core_data = d; host_ready = hr;
        if (rst || clr) begin
            sbq.delete();
            m_acc = 0; m_drop = 0; m_ovf = 0;
        end else begin
            pop_m = (sbq.size() != 0) && hr;
            if (cv && (sbq.size() < DEPTH || pop_m)) begin
                sbq.push_back({tg, d});
                if (m_acc < CMAX) m_acc++;
            end else if (cv) begin
                if (m_drop < CMAX) m_drop++;
                m_ovf = 1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input bit hr);
        step(0, 0, 0, 2'd0, '0, hr);
    endtask

    task automatic push(input logic [DW-1:0] d, input bit hr);
        step(0, 0, 1, 2'(d), d, hr);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks the held head stays put.
    initial begin
        logic [DW+1:0] exp_e, hold_d;
        bit            hold_v = 0;
        forever begin
            @(negedge clock);
            if (chk_en && !reset && !clear) begin
                if (hold_v && host_valid)
                    chk("head_stable", 64'({host_tag, host_data}), 64'(hold_d));
                if (host_valid && host_ready) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_pop", 64'(1), 64'(0));
                    end else begin
                        exp_e = sbq.pop_front();
                        chk("pop_data", 64'({host_tag, host_data}), 64'(exp_e));
                    end
                end
                hold_v = host_valid && !host_ready;
                hold_d = {host_tag, host_data};
            end else begin
                hold_v = 0;
            end
        end
    end

    always @(posedge clock) begin
        if (report)
            $display("core %0d report: fill=%0d accepted=%0d dropped=%0d overflow=%0b",
                     2, fill_level, accepted_count, dropped_count, overflow);
    end

    initial begin
        reset = 1; clear = 0; core_valid = 0; core_tag = '0; core_data = '0;
        host_ready = 0; report = 0;
        step(1, 0, 0, 2'd0, '0, 0);
        step(1, 0, 0, 2'd0, '0, 0);
        chk_en = 1;

        // Three results held, then drained in order.
        push(10, 0); push(20, 0); push(30, 0);
        chk("head_first", 64'(host_data), 64'd10);
        idle(0);
        repeat (3) idle(1);
        idle(0);

        // Ten results into an eight-deep FIFO: two drops.
        for (int i = 1; i <= 10; i++) push(DW'(i), 0);
        report = 1;
        idle(0);
        report = 0;
        repeat (9) idle(1);

        // Full FIFO with simultaneous pop and push.
        step(0, 1, 0, 2'd0, '0, 0);
        for (int i = 0; i < DEPTH; i++) push(DW'(100 + i), 0);
        push(99, 1);
        repeat (10) idle(1);

        // Continuous streaming wraps the pointers.
        for (int i = 0; i < 20; i++) push(DW'(i), 1);
        repeat (3) idle(1);

        // Reset mid-drain discards everything.
        for (int i = 0; i < 5; i++) push(DW'(50 + i), 0);
        idle(1);
        step(1, 0, 0, 2'd0, '0, 1);
        push(7, 0);
        chk("head_after_reset", 64'(host_data), 64'd7);
        idle(1);
        idle(0);

        // Drop counter saturates; clear wipes counters and overflow.
        for (int i = 0; i < DEPTH + 20; i++) push(DW'(200 + i), 0);
        idle(0);
        step(0, 1, 1, 2'd1, 32'hdead, 1);
        idle(0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 600; i++) begin
            int rdy_pct;
            rdy_pct = (i < 200) ? 30 : (i < 400) ? 70 : 50;
            step(0, $urandom_range(0, 79) == 0, $urandom_range(0, 99) < 60, 2'($urandom),
                 DW'($urandom), $urandom_range(0, 99) < rdy_pct);
        end
        repeat (DEPTH + 2) idle(1);
        check_state();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
